truth_table_sweeper: RTL and testbench

Clocked sequencer that exhaustively drives a 4-input combinational function block through all 16 input combinations in ascending order. It waits a programmable settle time per vector, captures the block's output into a 16-bit truth table, and compares it against a latched expected table. It sits between a lab-board/top-level control interface and the combinational unit under test (the `a, b, c, d -> f` style exercise blocks), replacing hand-written stimulus sequences with a start/done handshake.

---
 rtl/truth_table_sweeper.sv | 154 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Walks a 4-input combinational block through all input vectors in ascending
// order. It waits SETTLE cycles after each vector change, samples f_in into a
// captured truth table, and scores the capture against an expected table that
// is latched at start.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start, abort    begin a sweep (IDLE only) / abandon a running sweep
//   expected        expected truth table, latched on start
//   f_in            output of the function block under control
//   vec_out         input vector driven to the block ({a,b,c,d}, a is MSB)
//   busy, done      sweep in progress / one-cycle completion pulse
//   table_out       captured truth table (bit i = f for vector i)
//   mismatch_count  number of captured bits differing from expected
//   first_fail      lowest mismatching vector, valid with fail_valid
//   fail_valid      at least one mismatch recorded
//   pass            last completed sweep had no mismatches
//
// state | meaning
// IDLE  | waiting for start; results of the last sweep are held
// RUN   | driving vec_out, counting settle cycles, sampling f_in
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 f_in,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        mismatch_count,
  output logic [N_IN-1:0]      first_fail,
  output logic                 fail_valid,
  output logic                 pass
);

  localparam int              W        = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(W - 1);
  localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [W-1:0]      exp_q, exp_d;
  logic [W-1:0]      table_q, table_d;
  logic [N_IN:0]     mm_q, mm_d;
  logic [N_IN-1:0]   ff_q, ff_d;
  logic              fv_q, fv_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      mm_q    <= '0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      mm_q    <= mm_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    table_d = table_q;
    mm_d    = mm_q;
    ff_d    = ff_q;
    fv_d    = fv_q;
    pass_d  = pass_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          idx_d   = '0;
          exp_d   = expected;
          table_d = '0;
          mm_d    = '0;
          ff_d    = '0;
          fv_d    = 1'b0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        // Abort wins over a sample in the same cycle; partial results stay.
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == SETTLE_C) begin
          table_d[idx_q] = f_in;
          if (f_in != exp_q[idx_q]) begin
            mm_d = mm_q + (N_IN+1)'(1);
            if (!fv_q) begin
              ff_d = idx_q;
              fv_d = 1'b1;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b1;
            pass_d  = (mm_d == '0);
          end else begin
            idx_d = idx_q + N_IN'(1);
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign vec_out        = idx_q;
  assign busy           = (state_q == RUN);
  assign done           = done_q;
  assign table_out      = table_q;
  assign mismatch_count = mm_q;
  assign first_fail     = ff_q;
  assign fail_valid     = fv_q;
  assign pass           = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: two sweepers (SETTLE=0 and SETTLE=2) each drive a
// behavioural function block held as a 16-entry lookup. Each accepted start
// pushes the expected sweep result; a negedge monitor pops and scores on done.
module tb_truth_table_sweeper;

  localparam int SET0 = 0;
  localparam int SET1 = 2;

  typedef struct {
    logic [15:0] tbl;
    int          mm;
    int          ff;
    logic        pass;
    int          st;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s [2];
  logic        abort_s [2];
  logic [15:0] exp_s   [2];
  logic        f_s     [2];
  logic [3:0]  vec_s   [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic [15:0] tbl_s   [2];
  logic [4:0]  mm_s    [2];
  logic [3:0]  ff_s    [2];
  logic        fv_s    [2];
  logic        pass_s  [2];
  logic [15:0] fn_tbl  [2];
  logic        prev_done [2] = '{1'b0, 1'b0};

  int cyc = 0;
  int run_start [2] = '{0, 0};
  int n_pass = 0;
  int n_chk  = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign f_s[0] = fn_tbl[0][vec_s[0]];
  assign f_s[1] = fn_tbl[1][vec_s[1]];

  truth_table_sweeper #(.N_IN(4), .SETTLE(SET0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .expected(exp_s[0]), .f_in(f_s[0]), .vec_out(vec_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .table_out(tbl_s[0]), .mismatch_count(mm_s[0]),
    .first_fail(ff_s[0]), .fail_valid(fv_s[0]), .pass(pass_s[0]));

  truth_table_sweeper #(.N_IN(4), .SETTLE(SET1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .expected(exp_s[1]), .f_in(f_s[1]), .vec_out(vec_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .table_out(tbl_s[1]), .mismatch_count(mm_s[1]),
    .first_fail(ff_s[1]), .fail_valid(fv_s[1]), .pass(pass_s[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, want);
  endtask

  function automatic logic [15:0] parity_fn();
    logic [15:0] r;
    for (int v = 0; v < 16; v++) r[v] = ($countones(v) % 2) == 1;
    return r;
  endfunction

  // A full sweep captures the function itself; scoring is a table compare.
  function automatic exp_t model(input logic [15:0] fn, input logic [15:0] ex, input int st);
    exp_t e;
    logic [15:0] diff;
    diff   = fn ^ ex;
    e.tbl  = fn;
    e.mm   = $countones(diff);
    e.ff   = 0;
    for (int v = 15; v >= 0; v--) if (diff[v]) e.ff = v;
    e.pass = (e.mm == 0);
    e.st   = st;
    return e;
  endfunction

  // Called at a negedge; returns just after the start edge.
  task automatic start_sweep(input int d, input logic [15:0] ex, input bit push);
    exp_t e;
    exp_s[d]   = ex;
    start_s[d] = 1'b1;
    @(posedge clk);
    #1;
    start_s[d]   = 1'b0;
    run_start[d] = cyc;
    if (push) begin
      e = model(fn_tbl[d], ex, cyc);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while (done_s[d] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk($sformatf("timeout_done%0d", d), 0, 1);
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk($sformatf("%s_vec%0d", tag, d),  vec_s[d],  0);
    chk($sformatf("%s_busy%0d", tag, d), busy_s[d], 0);
    chk($sformatf("%s_done%0d", tag, d), done_s[d], 0);
    chk($sformatf("%s_tbl%0d", tag, d),  tbl_s[d],  0);
    chk($sformatf("%s_mm%0d", tag, d),   mm_s[d],   0);
    chk($sformatf("%s_ff%0d", tag, d),   ff_s[d],   0);
    chk($sformatf("%s_fv%0d", tag, d),   fv_s[d],   0);
    chk($sformatf("%s_pass%0d", tag, d), pass_s[d], 0);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int   s;
      exp_t e;
      s = (d == 0) ? SET0 : SET1;
      if (prev_done[d]) chk($sformatf("done_pulse%0d", d), done_s[d], 0);
      if (busy_s[d] === 1'b1 && rst_n === 1'b1)
        chk($sformatf("vec_step%0d", d), vec_s[d], ((cyc - run_start[d]) / (s + 1)) % 16);
      if (done_s[d] === 1'b1) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          chk($sformatf("unexpected_done%0d", d), 1, 0);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("latency%0d", d), cyc - e.st, 16 * (s + 1));
          chk($sformatf("table%0d", d),   tbl_s[d],   e.tbl);
          chk($sformatf("mm%0d", d),      mm_s[d],    e.mm);
          chk($sformatf("ff%0d", d),      ff_s[d],    e.ff);
          chk($sformatf("fv%0d", d),      fv_s[d],    e.mm != 0);
          chk($sformatf("pass%0d", d),    pass_s[d],  e.pass);
          chk($sformatf("busy_end%0d", d), busy_s[d], 0);
        end
      end
      prev_done[d] <= done_s[d];
    end
  end

  initial begin
    logic [15:0] fn, ex, mask, held;
    int n;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      abort_s[d] = 1'b0;
      exp_s[d]   = 16'h0;
      fn_tbl[d]  = parity_fn();
    end

    // Reset held 3 cycles with a start pulse inside it.
    @(negedge clk);
    start_s[0] = 1'b1; start_s[1] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk_zero(d, "rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_start_ignored0", busy_s[0], 0);
    chk("rst_start_ignored1", busy_s[1], 0);

    // Parity, clean and one-off expected, then stuck-at-0.
    @(negedge clk); start_sweep(1, 16'h6996, 1); wait_done(1);
    @(negedge clk); start_sweep(1, 16'h6997, 1); wait_done(1);
    fn_tbl[1] = 16'h0000;
    @(negedge clk); start_sweep(1, 16'h6996, 1); wait_done(1);
    fn_tbl[1] = parity_fn();

    // SETTLE=0, restart in the done cycle.
    @(negedge clk); start_sweep(0, 16'h6996, 1); wait_done(0);
    start_sweep(0, 16'h6997, 1);
    chk("restart_busy", busy_s[0], 1);
    chk("restart_tbl",  tbl_s[0],  0);
    chk("restart_mm",   mm_s[0],   0);
    chk("restart_fv",   fv_s[0],   0);
    chk("restart_pass", pass_s[0], 0);
    wait_done(0);

    // Mid-run start pulses and expected changes are ignored.
    @(negedge clk); start_sweep(1, 16'h6996, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_s[1] = 1'b1;
      exp_s[1]   = 16'hFFFF;
      @(negedge clk);
      start_s[1] = 1'b0;
      exp_s[1]   = 16'h0000;
    end
    wait_done(1);

    // Randomized functions with sparse expected-table errors.
    for (int i = 0; i < 8; i++) begin
      int d;
      d    = i % 2;
      fn   = 16'($urandom);
      mask = 16'($urandom & $urandom & $urandom);
      if (i % 3 == 0) mask = 16'h0;
      fn_tbl[d] = fn;
      @(negedge clk); start_sweep(d, fn ^ mask, 1); wait_done(d);
    end

    // Abort while vector 5 is driven.
    fn = 16'($urandom);
    ex = 16'($urandom);
    fn_tbl[1] = fn;
    @(negedge clk); start_sweep(1, ex, 0);
    n = 0;
    while (vec_s[1] !== 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("timeout_idx5", 0, 1);
    abort_s[1] = 1'b1;
    @(posedge clk); #1;
    abort_s[1] = 1'b0;
    chk("abort_busy", busy_s[1], 0);
    chk("abort_vec",  vec_s[1],  0);
    chk("abort_done", done_s[1], 0);
    chk("abort_tbl",  tbl_s[1],  fn & 16'h001F);
    chk("abort_mm",   mm_s[1],   $countones((fn ^ ex) & 16'h001F));
    chk("abort_fv",   fv_s[1],   ((fn ^ ex) & 16'h001F) != 0);
    chk("abort_pass", pass_s[1], 0);
    repeat (60) @(negedge clk);
    chk("abort_stays_idle", busy_s[1], 0);

    // Abort in IDLE leaves held results alone.
    held = fn & 16'h001F;
    abort_s[1] = 1'b1;
    @(negedge clk);
    abort_s[1] = 1'b0;
    @(negedge clk);
    chk("idle_abort_tbl",  tbl_s[1],  held);
    chk("idle_abort_busy", busy_s[1], 0);

    // Asynchronous reset mid-sweep, then a normal sweep.
    fn_tbl[1] = parity_fn();
    @(negedge clk); start_sweep(1, 16'h6997, 0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero(1, "midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); start_sweep(1, 16'h6996, 1); wait_done(1);

    repeat (3) @(negedge clk);
    chk("sb_empty0", q0.size(), 0);
    chk("sb_empty1", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
